// File: rtl/ram_copy_pkg.sv
// rtl/ram_copy_pkg.sv - shared state encoding and default widths for the RAM block copier
package ram_copy_pkg;

    localparam int DEFAULT_DATA_WIDTH    = 32;
    localparam int DEFAULT_ADDRESS_WIDTH = 12;
    localparam int DEFAULT_LEN_WIDTH     = DEFAULT_ADDRESS_WIDTH + 1;

    localparam int STATE_WIDTH = 2;

    typedef enum logic [STATE_WIDTH-1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } copy_state_t;

endpackage

// File: rtl/ram_block_copier_if.sv
// rtl/ram_block_copier_if.sv - single-port data RAM bus between the copier (master) and the RAM (slave)
interface ram_block_copier_if
    import ram_copy_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
);
    logic                     memWEn;
    logic [ADDRESS_WIDTH-1:0] memAddr;
    logic [DATA_WIDTH-1:0]    memDataIn;
    logic [DATA_WIDTH-1:0]    memDataOut;

    modport master (
        output memWEn,
        output memAddr,
        output memDataIn,
        input  memDataOut
    );

    modport slave (
        input  memWEn,
        input  memAddr,
        input  memDataIn,
        output memDataOut
    );

endinterface

// File: rtl/ram_copy_addr_gen.sv
// rtl/ram_copy_addr_gen.sv - source/destination pointers, word counter and last-word compare
module ram_copy_addr_gen
    import ram_copy_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int LEN_WIDTH     = DEFAULT_LEN_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic                     inc,
    input  logic [ADDRESS_WIDTH-1:0] src_addr,
    input  logic [ADDRESS_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]     len,
    output logic [ADDRESS_WIDTH-1:0] src_nxt,
    output logic [ADDRESS_WIDTH-1:0] dst_nxt,
    output logic [LEN_WIDTH-1:0]     word_count,
    output logic                     last
);

    logic [ADDRESS_WIDTH-1:0] src_ptr;
    logic [ADDRESS_WIDTH-1:0] dst_ptr;
    logic [LEN_WIDTH-1:0]     len_q;
    logic [LEN_WIDTH-1:0]     count_nxt;
    logic [LEN_WIDTH-1:0]     len_nxt;

    // Next pointer values; exposed so the top can register the RAM address for the coming state.
    // The +1 is ADDRESS_WIDTH bits wide, so 0xFFF rolls over to 0x000 without any extra logic.
    always_comb begin
        src_nxt   = src_ptr;
        dst_nxt   = dst_ptr;
        count_nxt = word_count;
        len_nxt   = len_q;
        if (load) begin
            src_nxt   = src_addr;
            dst_nxt   = dst_addr;
            count_nxt = '0;
            len_nxt   = len;
        end else if (inc) begin
            src_nxt   = src_ptr + ADDRESS_WIDTH'(1);
            dst_nxt   = dst_ptr + ADDRESS_WIDTH'(1);
            count_nxt = word_count + LEN_WIDTH'(1);
        end
    end

    // Pointer, counter and length registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_ptr    <= '0;
            dst_ptr    <= '0;
            word_count <= '0;
            len_q      <= '0;
        end else begin
            src_ptr    <= src_nxt;
            dst_ptr    <= dst_nxt;
            word_count <= count_nxt;
            len_q      <= len_nxt;
        end
    end

    // The word being written now is the final one when the count after it reaches len.
    assign last = ((word_count + LEN_WIDTH'(1)) == len_q);

endmodule

// File: rtl/ram_block_copier.sv
// rtl/ram_block_copier.sv - RAM block copy engine; optional fill mode under RAM_BLOCK_COPIER_FILL_EN
module ram_block_copier
    import ram_copy_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int LEN_WIDTH     = DEFAULT_LEN_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] srcAddr,
    input  logic [ADDRESS_WIDTH-1:0] dstAddr,
    input  logic [LEN_WIDTH-1:0]     len,
`ifdef RAM_BLOCK_COPIER_FILL_EN
    input  logic                     fillMode,
    input  logic [DATA_WIDTH-1:0]    fillValue,
`endif
    output logic                     busy,
    output logic                     done,
    output logic [LEN_WIDTH-1:0]     wordCount,
    ram_block_copier_if.master       mem
);

    copy_state_t state;
    copy_state_t state_nxt;

    logic                     wen_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    data_q;

    logic                     wen_nxt;
    logic [ADDRESS_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0]    data_nxt;
    logic                     busy_nxt;
    logic                     done_nxt;

    logic                     accept;
    logic                     load;
    logic                     inc;
    logic                     last;
    logic [ADDRESS_WIDTH-1:0] src_nxt;
    logic [ADDRESS_WIDTH-1:0] dst_nxt;

    // fill_sel/fill_word are what the coming cycle should use: the live inputs while a
    // start is being accepted, the latched copies for the rest of the transfer.
    logic                     fill_sel;
    logic [DATA_WIDTH-1:0]    fill_word;

`ifdef RAM_BLOCK_COPIER_FILL_EN
    logic                     fill_mode_q;
    logic [DATA_WIDTH-1:0]    fill_value_q;

    // Fill settings are captured together with the addresses when a start is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_mode_q  <= 1'b0;
            fill_value_q <= '0;
        end else if (accept) begin
            fill_mode_q  <= fillMode;
            fill_value_q <= fillValue;
        end
    end

    assign fill_sel  = (state == IDLE) ? fillMode  : fill_mode_q;
    assign fill_word = (state == IDLE) ? fillValue : fill_value_q;
`else
    assign fill_sel  = 1'b0;
    assign fill_word = '0;
`endif

    // Only IDLE listens to start; a start in any other state is dropped.
    assign accept = (state == IDLE) && start && (len != '0);
    assign load   = accept;
    assign inc    = (state == WR);

    ram_copy_addr_gen #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .LEN_WIDTH     (LEN_WIDTH)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .inc        (inc),
        .src_addr   (srcAddr),
        .dst_addr   (dstAddr),
        .len        (len),
        .src_nxt    (src_nxt),
        .dst_nxt    (dst_nxt),
        .word_count (wordCount),
        .last       (last)
    );

    // Next state, then the registered outputs decoded from the state being entered.
    always_comb begin
        state_nxt = state;
        wen_nxt   = 1'b0;
        addr_nxt  = addr_q;
        data_nxt  = data_q;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_nxt = FIN;
                    end else if (fill_sel) begin
                        state_nxt = WR;
                    end else begin
                        state_nxt = RD;
                    end
                end
            end
            RD: begin
                state_nxt = WR;
            end
            WR: begin
                if (last) begin
                    state_nxt = FIN;
                end else if (fill_sel) begin
                    state_nxt = WR;
                end else begin
                    state_nxt = RD;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Read data from the RD cycle is on memDataOut at the edge that enters WR,
        // so the write data register loads it on that same edge.
        case (state_nxt)
            RD: begin
                addr_nxt = src_nxt;
                busy_nxt = 1'b1;
            end
            WR: begin
                addr_nxt = dst_nxt;
                wen_nxt  = 1'b1;
                busy_nxt = 1'b1;
                data_nxt = fill_sel ? fill_word : mem.memDataOut;
            end
            FIN: begin
                done_nxt = 1'b1;
            end
            default: begin
                wen_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops memWEn straight away, abandoning any transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            wen_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            state  <= state_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
            wen_q  <= wen_nxt;
            addr_q <= addr_nxt;
            data_q <= data_nxt;
        end
    end

    assign mem.memWEn    = wen_q;
    assign mem.memAddr   = addr_q;
    assign mem.memDataIn = data_q;

endmodule

// File: tb/tb_ram_block_copier.sv
// tb/tb_ram_block_copier.sv - directed bench for ram_block_copier with a behavioural RAM
module tb_ram_block_copier;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] src_addr = '0;
    logic [11:0] dst_addr = '0;
    logic [12:0] len = '0;
    logic        fill_mode = 1'b0;
    logic [31:0] fill_value = '0;
    logic        busy;
    logic        done;
    logic [12:0] word_count;

    int total = 0;
    int bad = 0;

    logic [31:0] mem [0:4095];
    logic [31:0] dout = '0;
    logic [11:0] rq[$];
    logic [11:0] wq[$];

    int done_cyc, done_cnt, busy_cnt, busy_first, busy_last, wen_cnt;
    logic [12:0] wc_at_done;
    int seen_done;

    ram_block_copier_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12)) bus ();

    ram_block_copier dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .srcAddr   (src_addr),
        .dstAddr   (dst_addr),
        .len       (len),
`ifdef RAM_BLOCK_COPIER_FILL_EN
        .fillMode  (fill_mode),
        .fillValue (fill_value),
`endif
        .busy      (busy),
        .done      (done),
        .wordCount (word_count),
        .mem       (bus)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM: samples on the falling edge, dataOut holds during writes.
    always @(negedge clk) begin
        if (bus.memWEn) begin
            mem[bus.memAddr] = bus.memDataIn;
            wq.push_back(bus.memAddr);
        end else begin
            dout = mem[bus.memAddr];
            if (busy) rq.push_back(bus.memAddr);
        end
    end
    assign bus.memDataOut = dout;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Pulse start for one edge, then watch a bounded window; optionally re-pulse start at cycle rc.
    task automatic run_op(input logic [11:0] s, input logic [11:0] d, input logic [12:0] n,
                          input logic fm, input logic [31:0] fv, input int rc);
        rq.delete();
        wq.delete();
        @(posedge clk); #1;
        start = 1'b1; src_addr = s; dst_addr = d; len = n; fill_mode = fm; fill_value = fv;
        @(posedge clk); #1;
        start = 1'b0;
        done_cyc = 0; done_cnt = 0; busy_cnt = 0; busy_first = 0; busy_last = 0; wen_cnt = 0;
        wc_at_done = '0;
        for (int c = 1; c <= 2 * int'(n) + 6; c++) begin
            if (busy) begin
                busy_cnt++;
                if (busy_first == 0) busy_first = c;
                busy_last = c;
            end
            if (bus.memWEn) wen_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc = c;
                    wc_at_done = word_count;
                end
            end
            if (c == rc) begin
                start = 1'b1; src_addr = 12'h100; dst_addr = 12'h500; len = 13'd2;
            end else if (c == rc + 1) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_wc", 32'(word_count), 32'h0);
        check("rst_wen", 32'(bus.memWEn), 32'h0);
        check("rst_addr", 32'(bus.memAddr), 32'h0);
        check("rst_din", bus.memDataIn, 32'h0);
        rst_n = 1'b1;

        // Basic 4-word copy 0x100 -> 0x200
        mem[12'h100] = 32'hA000_000A;
        mem[12'h101] = 32'hB000_000B;
        mem[12'h102] = 32'hC000_000C;
        mem[12'h103] = 32'hD000_000D;
        run_op(12'h100, 12'h200, 13'd4, 1'b0, 32'h0, -10);
        check("cp_done_cyc", 32'(done_cyc), 32'd9);
        check("cp_done_cnt", 32'(done_cnt), 32'd1);
        check("cp_busy_first", 32'(busy_first), 32'd1);
        check("cp_busy_last", 32'(busy_last), 32'd8);
        check("cp_busy_cnt", 32'(busy_cnt), 32'd8);
        check("cp_wen_cnt", 32'(wen_cnt), 32'd4);
        check("cp_wc", 32'(wc_at_done), 32'd4);
        check("cp_m200", mem[12'h200], 32'hA000_000A);
        check("cp_m201", mem[12'h201], 32'hB000_000B);
        check("cp_m202", mem[12'h202], 32'hC000_000C);
        check("cp_m203", mem[12'h203], 32'hD000_000D);
        check("cp_m204", mem[12'h204], 32'h0);

        // len == 0: done one cycle later, RAM untouched
        run_op(12'h100, 12'h200, 13'd0, 1'b0, 32'h0, -10);
        check("z_done_cyc", 32'(done_cyc), 32'd1);
        check("z_done_cnt", 32'(done_cnt), 32'd1);
        check("z_wen_cnt", 32'(wen_cnt), 32'd0);
        check("z_writes", 32'(wq.size()), 32'd0);
        check("z_busy_cnt", 32'(busy_cnt), 32'd0);

        // Source wraps across the top of the address space
        mem[12'hFFE] = 32'h1111_0FFE;
        mem[12'hFFF] = 32'h2222_0FFF;
        mem[12'h000] = 32'h3333_0000;
        mem[12'h001] = 32'h4444_0001;
        run_op(12'hFFE, 12'h010, 13'd4, 1'b0, 32'h0, -10);
        check("wr_rd_n", 32'(rq.size()), 32'd4);
        if (rq.size() == 4) begin
            check("wr_rd0", 32'(rq[0]), 32'hFFE);
            check("wr_rd1", 32'(rq[1]), 32'hFFF);
            check("wr_rd2", 32'(rq[2]), 32'h000);
            check("wr_rd3", 32'(rq[3]), 32'h001);
        end
        check("wr_wr_n", 32'(wq.size()), 32'd4);
        if (wq.size() == 4) begin
            check("wr_wr0", 32'(wq[0]), 32'h010);
            check("wr_wr3", 32'(wq[3]), 32'h013);
        end
        check("wr_m010", mem[12'h010], 32'h1111_0FFE);
        check("wr_m011", mem[12'h011], 32'h2222_0FFF);
        check("wr_m012", mem[12'h012], 32'h3333_0000);
        check("wr_m013", mem[12'h013], 32'h4444_0001);

        // Second start mid-transfer is ignored
        mem[12'h500] = 32'h5E47_1E00;
        run_op(12'h100, 12'h400, 13'd4, 1'b0, 32'h0, 3);
        check("ig_done_cnt", 32'(done_cnt), 32'd1);
        check("ig_done_cyc", 32'(done_cyc), 32'd9);
        check("ig_writes", 32'(wq.size()), 32'd4);
        check("ig_m403", mem[12'h403], 32'hD000_000D);
        check("ig_m500", mem[12'h500], 32'h5E47_1E00);

        // Reset asserted during the second WR cycle of a len=8 copy
        for (int i = 0; i < 8; i++) begin
            mem[12'h600 + 12'(i)] = 32'h6000_0000 + 32'(i);
            mem[12'h700 + 12'(i)] = 32'hEEEE_EEEE;
        end
        @(posedge clk); #1;
        start = 1'b1; src_addr = 12'h600; dst_addr = 12'h700; len = 13'd8;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rs_pre_wen", 32'(bus.memWEn), 32'h1);
        rst_n = 1'b0;
        #1;
        check("rs_wen", 32'(bus.memWEn), 32'h0);
        check("rs_busy", 32'(busy), 32'h0);
        seen_done = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done) seen_done++;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) seen_done++;
        end
        check("rs_no_done", 32'(seen_done), 32'd0);
        check("rs_m700", mem[12'h700], 32'h6000_0000);
        check("rs_m701", mem[12'h701], 32'hEEEE_EEEE);
        check("rs_wc", 32'(word_count), 32'd0);

`ifdef RAM_BLOCK_COPIER_FILL_EN
        // Fill mode: one word per cycle, no reads
        run_op(12'h100, 12'h300, 13'd5, 1'b1, 32'hDEAD_BEEF, -10);
        check("fl_done_cyc", 32'(done_cyc), 32'd6);
        check("fl_reads", 32'(rq.size()), 32'd0);
        check("fl_wen_cnt", 32'(wen_cnt), 32'd5);
        check("fl_m300", mem[12'h300], 32'hDEAD_BEEF);
        check("fl_m304", mem[12'h304], 32'hDEAD_BEEF);
        check("fl_m305", mem[12'h305], 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
